// File: rtl/forward_scoreboard.sv
// forward_scoreboard: rs1/rs2 operand forwarding, long-latency scoreboard and stall watchdog.
// Optional FORWARD_STALL_PERF_EN adds the stall_cycles / sb_stall_cycles counters.
module forward_scoreboard #(
  parameter int XLEN          = 32,
  parameter int NUM_STAGES    = 2,
  parameter int STALL_TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [XLEN-1:0]            regs_rs1_rd_data,
  input  logic [XLEN-1:0]            regs_rs2_rd_data,
  input  logic [4:0]                 decode_r_rs1,
  input  logic [4:0]                 decode_r_rs2,
  input  logic                       decode_valid,
  input  logic [5*NUM_STAGES-1:0]    stage_rd,
  input  logic [NUM_STAGES-1:0]      stage_rd_wr_en,
  input  logic [XLEN*NUM_STAGES-1:0] stage_rd_wr_data,
  input  logic [NUM_STAGES-1:0]      stage_rd_valid,
  input  logic                       retire_en,
  input  logic                       wb_en,
  input  logic [4:0]                 wb_rd,
  input  logic                       flush,
  output logic [XLEN-1:0]            forward_rs1_data,
  output logic [XLEN-1:0]            forward_rs2_data,
  output logic                       execute_force_stall,
  output logic [31:0]                sb_busy,
  output logic                       stall_timeout
`ifdef FORWARD_STALL_PERF_EN
  ,
  output logic [31:0]                stall_cycles,
  output logic [31:0]                sb_stall_cycles
`endif
);

  localparam int CW  = $clog2(STALL_TIMEOUT + 1);
  localparam int OLD = NUM_STAGES - 1;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            stall;
    logic            sb_hit;
  } fwd_t;

  logic [31:0]   sb_q, sb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
  logic          sb_set;
  logic [4:0]    set_rd;
  logic          sb_stall;
  fwd_t          f1, f2;

  // Oldest stage scanned first so the youngest match overwrites it.
  function automatic fwd_t resolve(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rf
  );
    fwd_t r;
    logic hit;
    r.data   = rf;
    r.stall  = 1'b0;
    r.sb_hit = 1'b0;
    hit      = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (stage_rd_wr_en[i] && stage_rd[5*i +: 5] == rs) begin
        hit     = 1'b1;
        r.data  = stage_rd_wr_data[XLEN*i +: XLEN];
        r.stall = !stage_rd_valid[i];
      end
    end
    if (!hit && sb_q[rs]) begin
      r.stall  = 1'b1;
      r.sb_hit = 1'b1;
    end
    if (rs == 5'd0) begin
      r.data   = '0;
      r.stall  = 1'b0;
      r.sb_hit = 1'b0;
    end
    return r;
  endfunction

  assign f1 = resolve(decode_r_rs1, regs_rs1_rd_data);
  assign f2 = resolve(decode_r_rs2, regs_rs2_rd_data);

  assign forward_rs1_data    = f1.data;
  assign forward_rs2_data    = f2.data;
  assign execute_force_stall = decode_valid && (f1.stall || f2.stall);
  assign sb_stall            = decode_valid && (f1.sb_hit || f2.sb_hit);
  assign sb_busy             = sb_q;
  assign stall_timeout       = to_q;

  assign set_rd = stage_rd[5*OLD +: 5];
  assign sb_set = retire_en && stage_rd_wr_en[OLD] && !stage_rd_valid[OLD];

  // Scoreboard next state: set beats clear, flush beats both.
  always_comb begin
    sb_d = sb_q;
    if (wb_en) sb_d[wb_rd] = 1'b0;
    if (sb_set) sb_d[set_rd] = 1'b1;
    sb_d[0] = 1'b0;
    if (flush) sb_d = '0;
  end

  // Watchdog: saturating run-length of stall cycles, sticky flag.
  always_comb begin
    cnt_d = '0;
    to_d  = to_q;
    if (flush) begin
      to_d = 1'b0;
    end else if (execute_force_stall) begin
      if (cnt_q != CW'(STALL_TIMEOUT)) cnt_d = cnt_q + CW'(1);
      else cnt_d = cnt_q;
      if (cnt_d == CW'(STALL_TIMEOUT)) to_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q  <= '0;
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

`ifdef FORWARD_STALL_PERF_EN
  // Free-running stall counters, wrapping, untouched by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles    <= '0;
      sb_stall_cycles <= '0;
    end else begin
      if (execute_force_stall) stall_cycles <= stall_cycles + 32'd1;
      if (sb_stall) sb_stall_cycles <= sb_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
